// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32x32 register file: arbitrates pipeline writeback and a buffered
// multi-cycle result onto one write port. Define RF_WR_CTRL_CLEAR_EN to clear x1..x31 after reset.
module regfile_wr_ctrl #(
  parameter int MAX_WAIT = 4,
  parameter int AGE_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_wdata,
  output logic        mc_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic        busy,
  output logic        buf_pending
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic             buf_valid_q, buf_valid_d;
  logic [4:0]       buf_rd_q, buf_rd_d;
  logic [31:0]      buf_data_q, buf_data_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             clearing;
  logic             pw;

`ifdef RF_WR_CTRL_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e     state_q, state_d;
  logic [4:0] clr_cnt_q, clr_cnt_d;

  assign clearing = (state_q == ST_CLEAR);
  assign busy     = rst | clearing;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clearing) begin
      clr_cnt_d = clr_cnt_q + 5'd1;
      if (clr_cnt_q == 5'd31) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= 5'd1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
`else
  assign clearing = 1'b0;
  assign busy     = 1'b0;
`endif

  assign pw = pipe_we & (pipe_rd != 5'd0);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path through the
    // if/else chain leaves one unassigned, which would infer a latch.
    rf_we       = 1'b0;
    rf_rd       = 5'd0;
    rf_wdata    = 32'd0;
    mc_ready    = 1'b0;
    stall_req   = 1'b0;
    buf_pending = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    age_d       = age_q;

    if (rst) begin
      // Outputs stay quiet; the register stage discards the buffer.
    end else if (clearing) begin
`ifdef RF_WR_CTRL_CLEAR_EN
      rf_we = 1'b1;
      rf_rd = clr_cnt_q;
`endif
    end else begin
      mc_ready    = ~buf_valid_q;
      buf_pending = buf_valid_q;
      stall_req   = buf_valid_q & (age_q == AGE_MAX);

      if (pw) begin
        rf_we    = 1'b1;
        rf_rd    = pipe_rd;
        rf_wdata = pipe_wdata;
        // A younger pipeline write to the same register makes the buffered value stale.
        if (buf_valid_q && (pipe_rd == buf_rd_q)) buf_valid_d = 1'b0;
      end else if (buf_valid_q) begin
        rf_we       = 1'b1;
        rf_rd       = buf_rd_q;
        rf_wdata    = buf_data_q;
        buf_valid_d = 1'b0;
      end

      if (buf_valid_q && buf_valid_d && (age_q != AGE_MAX)) age_d = age_q + AGE_W'(1);

      // mc_ready implies an empty buffer, so a load never collides with a drain.
      if (mc_valid && mc_ready && (mc_rd != 5'd0)) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = mc_rd;
        buf_data_d  = mc_wdata;
        age_d       = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      age_q       <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      age_q       <= age_d;
    end
  end

  // NOTE: the buffer payload is qualified by buf_valid_q, so it is deliberately left unreset.
  always_ff @(posedge clk) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

endmodule
